// File: rtl/ok_dram_pkg.sv
// ok_dram_pkg: shared types, parameter limits and depth helper for ok_dram_dual_clr
package ok_dram_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam int DATA_WIDTH_MIN = 1;
  localparam int DATA_WIDTH_MAX = 64;
  localparam int ADDR_WIDTH_MIN = 2;
  localparam int ADDR_WIDTH_MAX = 10;
  function automatic int depth(input int addr_width);
    return 1 << addr_width;
  endfunction
endpackage

// File: rtl/ok_dram_dual_clr_if.sv
// ok_dram_dual_clr_if: user-side bus of the self-clearing dual-read RAM
// master drives we/addrA/addrB/din/clear; slave returns doutA/doutB/busy/wr_drop
interface ok_dram_dual_clr_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] addrA;
  logic [ADDR_WIDTH-1:0] addrB;
  logic [DATA_WIDTH-1:0] din;
  logic                  clear;
  logic [DATA_WIDTH-1:0] doutA;
  logic [DATA_WIDTH-1:0] doutB;
  logic                  busy;
  logic                  wr_drop;
  modport master (output we, addrA, addrB, din, clear, input doutA, doutB, busy, wr_drop);
  modport slave  (input we, addrA, addrB, din, clear, output doutA, doutB, busy, wr_drop);
endinterface

// File: rtl/ok_dram_clear_seq.sv
// ok_dram_clear_seq: clear sweep FSM that owns the RAM write port
// in: wclk, reset, we, clear, addr, din; out: busy, wr_drop (registered),
// mem_we/mem_addr/mem_din (effective write towards the array)
module ok_dram_clear_seq
  import ok_dram_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 6,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  wclk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  wr_drop,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din
);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  busy_q, busy_d;
  logic                  wr_drop_q, wr_drop_d;
  // ptr sits at 0 whenever READY, so a restart or idle both just load 0
  always_comb begin
    state_d   = clear ? CLEAR : (state_q == CLEAR && &ptr_q) ? READY : state_q;
    ptr_d     = (clear || state_q == READY) ? '0 : ptr_q + ADDR_WIDTH'(1);
    busy_d    = state_d == CLEAR;
    wr_drop_d = we && busy_q;
  end
  always_ff @(posedge wclk) begin
    if (reset) begin
      state_q   <= CLEAR;
      ptr_q     <= '0;
      busy_q    <= 1'b1;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
    end
  end
  // the sweep owns the port while busy; a user write is only taken when READY
  assign mem_we   = !reset && (busy_q || we);
  assign mem_addr = busy_q ? ptr_q : addr;
  assign mem_din  = busy_q ? CLEAR_VALUE : din;
  assign busy     = busy_q;
  assign wr_drop  = wr_drop_q;
endmodule

// File: rtl/ok_dram.sv
// ok_dram_dual_clr: dual-read distributed RAM with built-in clear sweep
// ports: wclk, reset (sync, active-high), bus (ok_dram_dual_clr_if.slave)
// define OK_DRAM_OUTREG_EN for registered doutA/doutB (one-cycle latency);
// default build reads combinationally from the array
module ok_dram_dual_clr
  import ok_dram_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 6,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input logic                wclk,
  input logic                reset,
  ok_dram_dual_clr_if.slave  bus
);
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem [depth(ADDR_WIDTH)];
  logic [DATA_WIDTH-1:0] rd_a, rd_b;
  ok_dram_clear_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CLEAR_VALUE(CLEAR_VALUE)
  ) u_seq (
    .wclk    (wclk),
    .reset   (reset),
    .we      (bus.we),
    .clear   (bus.clear),
    .addr    (bus.addrA),
    .din     (bus.din),
    .busy    (bus.busy),
    .wr_drop (bus.wr_drop),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_din (mem_din)
  );
  always_ff @(posedge wclk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
  end
  // a half-cleared array is never exposed
  always_comb begin
    rd_a = bus.busy ? CLEAR_VALUE : mem[bus.addrA];
    rd_b = bus.busy ? CLEAR_VALUE : mem[bus.addrB];
  end
`ifdef OK_DRAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;
  always_comb begin
    dout_a_d = rd_a;
    dout_b_d = rd_b;
  end
  always_ff @(posedge wclk) begin
    if (reset) begin
      dout_a_q <= CLEAR_VALUE;
      dout_b_q <= CLEAR_VALUE;
    end else begin
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
    end
  end
  assign bus.doutA = dout_a_q;
  assign bus.doutB = dout_b_q;
`else
  assign bus.doutA = rd_a;
  assign bus.doutB = rd_b;
`endif
endmodule
